// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong match controller.
// Holds the FSM states, score width and the digit patterns.
package pong_pkg;

  localparam int SCORE_W = 3;

  localparam int DEF_WIN_SCORE    = 5;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_BLINK_CYCLES = 25000000;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  // Active-low gfedcba pattern for one decimal digit.
  function automatic logic [6:0] seg7_digit(input score_t d);
    logic [6:0] s;
    s = 7'b1111111;
    case (d)
      3'd0: s = 7'b1000000;
      3'd1: s = 7'b1111001;
      3'd2: s = 7'b0100100;
      3'd3: s = 7'b0110000;
      3'd4: s = 7'b0011001;
      3'd5: s = 7'b0010010;
      3'd6: s = 7'b0000010;
      3'd7: s = 7'b1111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_seg7.sv
// Score digit driver for a 7-segment display.
// The winning score flashes with blink; lower digits stay steady.
import pong_pkg::*;

module score_seg7 #(
  parameter int WIN_SCORE = DEF_WIN_SCORE
) (
  input  logic [SCORE_W-1:0] score,
  input  logic               blink,
  output logic [6:0]         seg
);

  localparam score_t S_WIN = SCORE_W'(WIN_SCORE);

  // Blank the winning digit during the off half of the blink.
  always_comb begin
    seg = seg7_digit(score);
    if (score == S_WIN && blink)
      seg = 7'b1111111;
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencing for pong: serve, play, scoring, game over.
// Scores and serve direction follow misses reported by the ball path.
import pong_pkg::*;

module pong_match_ctrl #(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int BLINK_CYCLES = DEF_BLINK_CYCLES
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               new_game,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_reset,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               numbers_active,
  output logic               game_over,
  output logic               winner,
  output logic               blink
);

  localparam int BW =
    (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [7:0]    S_LOAD = 8'(SERVE_FRAMES);
  localparam score_t        S_WIN  = SCORE_W'(WIN_SCORE);

  state_t        state;
  logic [7:0]    srv_cnt;
  logic [BW-1:0] blk_cnt;
  logic          in_rally;

  assign in_rally = (state == ST_SERVE) ||
                    (state == ST_PLAY)  ||
                    (state == ST_POINT);

  // Level outputs come straight from the state.
  assign ball_run       = (state == ST_PLAY);
  assign numbers_active = (state != ST_PLAY);
  assign game_over      = (state == ST_OVER);

  // Match FSM with its counters and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      srv_cnt    <= '0;
      blk_cnt    <= '0;
      score1     <= '0;
      score2     <= '0;
      serve_dir  <= 1'b0;
      winner     <= 1'b0;
      blink      <= 1'b0;
      ball_reset <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      if (new_game) begin
        score1    <= '0;
        score2    <= '0;
        serve_dir <= 1'b0;
        blink     <= 1'b0;
        blk_cnt   <= '0;
        state     <= ST_IDLE;
      end else if (!start && in_rally) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              ball_reset <= 1'b1;
              srv_cnt    <= S_LOAD;
              state      <= ST_SERVE;
            end
          end
          ST_SERVE: begin
            if (frame_tick) begin
              srv_cnt <= srv_cnt - 8'd1;
              if (srv_cnt <= 8'd1)
                state <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (miss_left && !miss_right) begin
              if (score2 != S_WIN)
                score2 <= score2 + 1'b1;
              serve_dir <= 1'b0;
            end else if (miss_right && !miss_left) begin
              if (score1 != S_WIN)
                score1 <= score1 + 1'b1;
              serve_dir <= 1'b1;
            end
            if (miss_left || miss_right)
              state <= ST_POINT;
          end
          ST_POINT: begin
            if (score1 == S_WIN || score2 == S_WIN) begin
              winner  <= (score2 == S_WIN);
              blk_cnt <= '0;
              blink   <= 1'b0;
              state   <= ST_OVER;
            end else begin
              ball_reset <= 1'b1;
              srv_cnt    <= S_LOAD;
              state      <= ST_SERVE;
            end
          end
          ST_OVER: begin
            if (blk_cnt == B_LAST) begin
              blk_cnt <= '0;
              blink   <= ~blink;
            end else begin
              blk_cnt <= blk_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl and its score digit drivers.
// Directed scenarios, then random traffic against a match model.
module tb_pong_match_ctrl;

  localparam int WIN = 2;
  localparam int SF  = 3;
  localparam int BC  = 4;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_PLAY  = 2;
  localparam int P_POINT = 3;
  localparam int P_OVER  = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       new_game = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_reset, ball_run, serve_dir;
  logic [2:0] score1, score2;
  logic       numbers_active, game_over, winner, blink;
  logic [6:0] seg1, seg2;

  int n_checks = 0;
  int n_errors = 0;

  pong_match_ctrl #(
    .WIN_SCORE(WIN),
    .SERVE_FRAMES(SF),
    .BLINK_CYCLES(BC)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .frame_tick(frame_tick),
    .start(start),
    .new_game(new_game),
    .miss_left(miss_left),
    .miss_right(miss_right),
    .ball_reset(ball_reset),
    .ball_run(ball_run),
    .serve_dir(serve_dir),
    .score1(score1),
    .score2(score2),
    .numbers_active(numbers_active),
    .game_over(game_over),
    .winner(winner),
    .blink(blink)
  );

  score_seg7 #(.WIN_SCORE(WIN)) u_seg1 (
    .score(score1),
    .blink(blink),
    .seg(seg1)
  );

  score_seg7 #(.WIN_SCORE(WIN)) u_seg2 (
    .score(score2),
    .blink(blink),
    .seg(seg2)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model state
  int m_ph   = P_IDLE;
  int m_srv  = 0;
  int m_s1   = 0;
  int m_s2   = 0;
  int m_sd   = 0;
  int m_win  = 0;
  int m_br   = 0;
  int m_over = 0;

  logic [6:0] digit_tab [8] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
  };

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Match rules, advanced once per clock edge.
  initial begin
    forever begin
      @(posedge CLOCK_50 or posedge reset);
      if (reset) begin
        m_ph = P_IDLE; m_srv = 0; m_s1 = 0; m_s2 = 0;
        m_sd = 0; m_win = 0; m_br = 0; m_over = 0;
      end else begin
        m_br = 0;
        if (new_game) begin
          m_s1 = 0; m_s2 = 0; m_sd = 0;
          m_ph = P_IDLE;
        end else if (!start && m_ph inside {P_SERVE, P_PLAY, P_POINT}) begin
          m_ph = P_IDLE;
        end else if (m_ph == P_IDLE) begin
          if (start) begin
            m_br = 1; m_srv = SF; m_ph = P_SERVE;
          end
        end else if (m_ph == P_SERVE) begin
          if (frame_tick) begin
            m_srv = m_srv - 1;
            if (m_srv == 0) m_ph = P_PLAY;
          end
        end else if (m_ph == P_PLAY) begin
          if (miss_left && !miss_right) begin
            m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
            m_sd = 0;
          end
          if (miss_right && !miss_left) begin
            m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
            m_sd = 1;
          end
          if (miss_left || miss_right) m_ph = P_POINT;
        end else if (m_ph == P_POINT) begin
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_win = (m_s2 == WIN) ? 1 : 0;
            m_over = 0;
            m_ph = P_OVER;
          end else begin
            m_br = 1; m_srv = SF; m_ph = P_SERVE;
          end
        end else begin
          m_over = m_over + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      int eb;
      @(negedge CLOCK_50);
      eb = (m_ph == P_OVER) ? ((m_over / BC) % 2) : 0;
      chk("ball_reset", 32'(ball_reset), 32'(m_br));
      chk("ball_run", 32'(ball_run), 32'(m_ph == P_PLAY));
      chk("serve_dir", 32'(serve_dir), 32'(m_sd));
      chk("score1", 32'(score1), 32'(m_s1));
      chk("score2", 32'(score2), 32'(m_s2));
      chk("numbers_active", 32'(numbers_active),
          32'(m_ph != P_PLAY));
      chk("game_over", 32'(game_over), 32'(m_ph == P_OVER));
      chk("blink", 32'(blink), 32'(eb));
      if (m_ph == P_OVER)
        chk("winner", 32'(winner), 32'(m_win));
      chk("seg1", 32'(seg1),
          32'((m_s1 == WIN && eb == 1) ? 7'h7F : digit_tab[m_s1]));
      chk("seg2", 32'(seg2),
          32'((m_s2 == WIN && eb == 1) ? 7'h7F : digit_tab[m_s2]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic serve3();
    repeat (SF) tick();
  endtask

  task automatic pulse_l();
    miss_left = 1'b1; cyc(1); miss_left = 1'b0;
  endtask

  task automatic pulse_r();
    miss_right = 1'b1; cyc(1); miss_right = 1'b0;
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    cyc(2);
    chk("rst numbers_active", 32'(numbers_active), 32'd1);
    chk("rst score1", 32'(score1), 32'd0);
    chk("rst seg1", 32'(seg1), 32'h40);

    reset = 1'b0; start = 1'b1;
    cyc(1);
    chk("start ball_reset", 32'(ball_reset), 32'd1);
    cyc(1);
    chk("ball_reset one cycle", 32'(ball_reset), 32'd0);
    tick(); tick();
    chk("serve holds", 32'(ball_run), 32'd0);
    tick();
    chk("play after 3 ticks", 32'(ball_run), 32'd1);

    pulse_r();
    chk("miss_r score1", 32'(score1), 32'd1);
    chk("miss_r serve_dir", 32'(serve_dir), 32'd1);
    chk("point ball_run", 32'(ball_run), 32'd0);
    cyc(1);
    chk("point exit ball_reset", 32'(ball_reset), 32'd1);
    serve3();
    pulse_l();
    chk("miss_l score2", 32'(score2), 32'd1);
    chk("miss_l serve_dir", 32'(serve_dir), 32'd0);
    cyc(1);
    serve3();
    pulse_l();
    chk("second miss_l score2", 32'(score2), 32'd2);
    cyc(1);
    chk("over game_over", 32'(game_over), 32'd1);
    chk("over winner", 32'(winner), 32'd1);
    chk("over blink start", 32'(blink), 32'd0);
    chk("over seg2 lit", 32'(seg2), 32'h24);
    cyc(3);
    chk("blink before wrap", 32'(blink), 32'd0);
    cyc(1);
    chk("blink after 4", 32'(blink), 32'd1);
    chk("seg2 blanked", 32'(seg2), 32'h7F);
    cyc(4);
    chk("blink after 8", 32'(blink), 32'd0);
    start = 1'b0;
    cyc(3);
    chk("over ignores start", 32'(game_over), 32'd1);
    new_game = 1'b1; cyc(1); new_game = 1'b0;
    chk("new_game game_over", 32'(game_over), 32'd0);
    chk("new_game score1", 32'(score1), 32'd0);
    chk("new_game score2", 32'(score2), 32'd0);

    start = 1'b1;
    cyc(1);
    serve3();
    pulse_r();
    cyc(1);
    serve3();
    miss_left = 1'b1; miss_right = 1'b1;
    cyc(1);
    miss_left = 1'b0; miss_right = 1'b0;
    chk("both score1", 32'(score1), 32'd1);
    chk("both score2", 32'(score2), 32'd0);
    chk("both serve_dir", 32'(serve_dir), 32'd1);
    chk("both point", 32'(ball_run), 32'd0);
    cyc(1);
    chk("both ball_reset", 32'(ball_reset), 32'd1);

    pulse_l();
    chk("serve miss ignored", 32'(score2), 32'd0);
    serve3();
    chk("back in play", 32'(ball_run), 32'd1);
    start = 1'b0;
    cyc(1);
    chk("stop ball_run", 32'(ball_run), 32'd0);
    chk("stop keeps score1", 32'(score1), 32'd1);
    pulse_r();
    chk("idle miss ignored", 32'(score1), 32'd1);

    start = 1'b1;
    cyc(1);
    serve3();
    chk("play before reset", 32'(ball_run), 32'd1);
    reset = 1'b1;
    #1;
    chk("async rst score1", 32'(score1), 32'd0);
    chk("async rst ball_run", 32'(ball_run), 32'd0);
    chk("async rst numbers", 32'(numbers_active), 32'd1);
    chk("async rst ball_reset", 32'(ball_reset), 32'd0);
    cyc(2);
    chk("held rst ball_reset", 32'(ball_reset), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      @(negedge CLOCK_50);
      start      = ($urandom_range(0, 99) < 96);
      frame_tick = ($urandom_range(0, 99) < 40);
      miss_left  = ($urandom_range(0, 99) < 12);
      miss_right = ($urandom_range(0, 99) < 12);
      new_game   = ($urandom_range(0, 99) < 2);
      reset      = ($urandom_range(0, 999) < 5);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5: score that ends the match; legal range 1..7.
REQ-002 Parameter SERVE_FRAMES, default 60: frame ticks the ball is held at centre before each serve; legal range 1..255.
REQ-003 Parameter BLINK_CYCLES, default 25000000: clock cycles per blink half-period in OVER.
REQ-004 CLOCK_50  in  1  single clock; all flops rise-edge on it.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame from the VGA timing logic.
REQ-007 start  in  1  level: play enable.
REQ-008 new_game  in  1  one-cycle pulse: clears scores and returns to IDLE.
REQ-009 miss_left  in  1  one-cycle pulse from the ball datapath: ball passed player 1's goal line.
REQ-010 miss_right  in  1  one-cycle pulse from the ball datapath: ball passed player 2's goal line.
REQ-011 ball_reset  out  1  one-cycle pulse: recentre ball and set speed to default.
REQ-012 ball_run  out  1  level: ball datapath may move the ball.
REQ-013 serve_dir  out  1  0 = serve toward player 1 (left), 1 = toward player 2 (right).
REQ-014 score1, score2  out  3 each  match scores.
REQ-015 numbers_active  out  1  level: draw large score digits on screen.
REQ-016 game_over  out  1  level: high in OVER only.
REQ-017 winner  out  1  0 = player 1, 1 = player 2; valid only while game_over is high.
REQ-018 blink  out  1  toggles every BLINK_CYCLES while in OVER; 0 elsewhere.

Function
REQ-019 FSM states: IDLE, SERVE, PLAY, POINT, OVER; state is registered, and all outputs are registered or decoded from state only.
REQ-020 IDLE: ball_run=0, numbers_active=1; when start=1, assert ball_reset for one cycle, load the serve counter with SERVE_FRAMES, and go to SERVE.
REQ-021 SERVE: ball_run=0, numbers_active=1; decrement the serve counter on each frame_tick; on the tick that reaches 0, go to PLAY next cycle.
REQ-022 PLAY: ball_run=1, numbers_active=0.
REQ-023 PLAY, miss_left only: score2 increments by 1, serve_dir<=0, go to POINT.
REQ-024 PLAY, miss_right only: score1 increments by 1, serve_dir<=1, go to POINT.
REQ-025 PLAY, miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, go to POINT.
REQ-026 POINT lasts exactly one cycle with ball_run=0.
REQ-027 POINT exit: if score1 or score2 equals WIN_SCORE, go to OVER, set winner, and clear the blink counter and blink.
REQ-028 POINT exit otherwise: pulse ball_reset, reload the serve counter, go to SERVE.
REQ-029 Miss pulses outside PLAY are ignored.
REQ-030 Scores saturate at WIN_SCORE; no wrap-around.
REQ-031 start=0 in SERVE, PLAY or POINT: go to IDLE next cycle, scores retained.
REQ-032 start=0 does not exit OVER.
REQ-033 new_game in any state, including same-cycle with a miss: scores<=0, serve_dir<=0, go to IDLE; new_game has priority over all other events.
REQ-034 OVER: ball_run=0, numbers_active=1, game_over=1; blink counter wraps at BLINK_CYCLES-1 and toggles blink on wrap; only new_game exits.
REQ-035 Latency: each miss pulse is reflected in its score output on the next clock edge.

Reset
REQ-036 Reset asserted: state=IDLE, score1=score2=0, serve_dir=0, winner=0, blink=0, ball_reset=0, ball_run=0, game_over=0, numbers_active=1, serve and blink counters = 0.
REQ-037 Reset mid-SERVE or mid-PLAY: immediate return to reset values, with no ball_reset pulse emitted during or after reset.

Structure
REQ-038 Package pong_pkg holds the state enumeration, score width (3), and the default WIN_SCORE, SERVE_FRAMES and BLINK_CYCLES constants.
REQ-039 One sub-module, score_seg7, converts a 3-bit score to an active-low 7-segment pattern (0-4 steady, WIN_SCORE gated by blink); it is instantiated twice at the top level, outside this block.

Verification (SERVE_FRAMES=3, WIN_SCORE=2, BLINK_CYCLES=4)
REQ-040 Release reset, start=1 -> one ball_reset pulse; SERVE for 3 frame_ticks; ball_run=1 on the cycle after the third tick.
REQ-041 In PLAY, miss_right -> score1=1 next edge, serve_dir=1, POINT one cycle, ball_reset pulse, SERVE.
REQ-042 Two miss_left events -> score2=2, OVER, game_over=1, winner=1, blink toggles every 4 cycles; start=0 -> remains OVER; new_game -> IDLE with scores 0.
REQ-043 miss_left and miss_right in the same PLAY cycle -> scores unchanged, serve_dir unchanged, POINT then SERVE.
REQ-044 Miss pulses during SERVE and IDLE -> no score change; start=0 in PLAY -> IDLE with scores retained.
REQ-045 Reset asserted mid-PLAY with score1=1 -> all outputs at reset values, including numbers_active=1.
